// File: rtl/totp_pkg.sv
// Shared TOTP constants, FSM encoding and datapath helpers.
// Optional trace output in totp_sampler is enabled by SAMPLER_TRACE_EN.
package totp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRUNC,
    S_MOD,
    S_BCD,
    S_DONE
  } state_t;

  localparam int TOTP_MODULUS    = 1_000_000;
  localparam int TOTP_DIGITS     = 6;
  localparam int MOD_STEPS       = 12;
  localparam int BCD_STEPS       = 20;
  localparam int SAMPLER_LATENCY = 34;

  localparam int DIGEST_W = 160;
  localparam int BIN_W    = 20;
  localparam int BCD_W    = 4 * TOTP_DIGITS;

  // Add 3 to every nibble >= 5 (double-dabble pre-shift correction).
  function automatic logic [BCD_W-1:0] dd_adjust(
    input logic [BCD_W-1:0] v
  );
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < TOTP_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5)
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Byte idx of the digest, byte 0 being the most significant.
  function automatic logic [7:0] digest_byte(
    input logic [DIGEST_W-1:0] d,
    input logic [4:0]          idx
  );
    return d[{5'd19 - idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/totp_sampler_bin2bcd_dd.sv
// Sequential double-dabble: 20-bit binary to six BCD digits.
// Ports: clk, rst, start (loads bin), bin, busy, bcd (valid when !busy).
module bin2bcd_dd
  import totp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic [BCD_W-1:0] bcd
);

  logic [4:0]       cnt;
  logic [BIN_W-1:0] sh;
  logic [BCD_W-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      sh  <= '0;
      acc <= '0;
    end else if (start) begin
      cnt <= 5'(BCD_STEPS);
      sh  <= bin;
      acc <= '0;
    end else if (cnt != 5'd0) begin
      {acc, sh} <= {dd_adjust(acc), sh} << 1;
      cnt <= cnt - 5'd1;
    end
  end

  assign busy = (cnt != 5'd0);
  assign bcd  = acc;

endmodule

// File: rtl/totp_sampler.sv
// TOTP dynamic truncation, mod 10^6 and BCD conversion of an HMAC digest.
// Ports: clk, rst, sample_init, digest -> sample_ready, sample_output.
// Define SAMPLER_TRACE_EN to print offset/code, remainder and digits.
module totp_sampler
  import totp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_init,
  input  logic [DIGEST_W-1:0] digest,
  output logic                sample_ready,
  output logic [BCD_W-1:0]    sample_output
);

  localparam logic [31:0] MOD_BASE = 32'(TOTP_MODULUS);

  state_t              state, state_n;
  logic [4:0]          cnt;
  logic [DIGEST_W-1:0] dig_q;
  logic [31:0]         rem, rem_n, sub;
  logic [31:0]         word, code;
  logic [3:0]          off;
  logic                mod_last;
  logic                dd_busy;
  logic [BCD_W-1:0]    dd_bcd;

  // Offset <= 15 keeps offset+3 <= 18, so byte 19 is
  // only reached through the offset nibble itself.
  always_comb begin
    off  = dig_q[3:0];
    word = '0;
    for (int i = 0; i < 4; i++)
      word = {word[23:0],
              digest_byte(dig_q, {1'b0, off} + 5'(i))};
    code = word & 32'h7FFF_FFFF;
  end

  // Restoring step: subtract 10^6 * 2^k when it fits.
  always_comb begin
    sub      = MOD_BASE << cnt[3:0];
    rem_n    = (rem >= sub) ? rem - sub : rem;
    mod_last = (state == S_MOD) && (cnt == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (sample_init) state_n = S_TRUNC;
      S_TRUNC: state_n = S_MOD;
      S_MOD:   if (cnt == 5'd0) state_n = S_BCD;
      S_BCD:   if (cnt == 5'd0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dig_q         <= '0;
      rem           <= '0;
      cnt           <= '0;
      sample_ready  <= 1'b1;
      sample_output <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (sample_init) begin
            dig_q        <= digest;
            sample_ready <= 1'b0;
          end
        end
        S_TRUNC: begin
          rem <= code;
          cnt <= 5'(MOD_STEPS - 1);
        end
        S_MOD: begin
          rem <= rem_n;
          cnt <= (cnt == 5'd0) ? 5'(BCD_STEPS - 1)
                               : cnt - 5'd1;
        end
        S_BCD: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        S_DONE: begin
          if (!dd_busy) sample_output <= dd_bcd;
          sample_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Converter is loaded with the final remainder on the
  // last MOD edge so its 20 shifts span the BCD state.
  bin2bcd_dd u_dd (
    .clk   (clk),
    .rst   (rst),
    .start (mod_last),
    .bin   (rem_n[BIN_W-1:0]),
    .busy  (dd_busy),
    .bcd   (dd_bcd)
  );

`ifdef SAMPLER_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_TRUNC)
        $display("totp_sampler: offset=%0d code=%08h",
                 off, code);
      if (mod_last)
        $display("totp_sampler: remainder=%0d",
                 rem_n[BIN_W-1:0]);
      if (state == S_DONE)
        $display("totp_sampler: digits=%06h", dd_bcd);
    end
  end
`else
`endif

endmodule

// File: doc/totp_sampler.md
TOTP_SAMPLER -- requirements
Module: totp_sampler

Interface
REQ-001 The block SHALL have one clock and one reset: clk input, rst input (synchronous, active-high); no other clock or reset.
REQ-002 The port list SHALL be exactly as follows, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- sample_init  input  1  one-cycle start pulse from the controller
- digest  input  160  outer HMAC-SHA1 digest, byte 0 = digest[159:152]; must be valid in the sample_init cycle
- sample_ready  output  1  high = idle/result valid; low = busy
- sample_output  output  24  six BCD digits, most significant digit in [23:20]

Function
REQ-003 On a clk edge with sample_init=1 and state IDLE, the block SHALL capture digest, drive sample_ready low and enter TRUNC.
REQ-004 In TRUNC (one cycle), the block SHALL form the truncated value as follows:
- offset = digest[3:0]
- word = bytes offset..offset+3, big-endian
- code = word with bit 31 cleared (31-bit result)
REQ-005 In MOD (exactly 12 cycles), the block SHALL compute code mod 1_000_000 by restoring subtraction of 1_000_000*2^k for k = 11 down to 0, one k per cycle.
REQ-006 In BCD (exactly 20 cycles), the block SHALL convert the 20-bit remainder to six BCD digits by double-dabble, one shift per cycle.
REQ-007 In DONE (one cycle), the block SHALL load sample_output, set sample_ready=1 and return to IDLE.
REQ-008 sample_ready SHALL rise on the 34th clk edge after the capture edge.
REQ-009 The states SHALL be IDLE, TRUNC, MOD, BCD and DONE, and the block SHALL have no other transitions than the following:
- IDLE->TRUNC on sample_init
- TRUNC->MOD
- MOD->BCD after 12 cycles
- BCD->DONE after 20 cycles
- DONE->IDLE
REQ-010 sample_init asserted in any state other than IDLE SHALL be ignored; the in-flight computation SHALL be unaffected.
REQ-011 sample_init held high for several cycles SHALL start exactly one computation, on the first edge in IDLE; a new computation can start no earlier than the cycle after DONE.
REQ-012 sample_output SHALL hold its last value while busy and change only in DONE.
REQ-013 The digest input SHALL be ignored after the capture edge.
REQ-014 Offset 15 SHALL use bytes 15..18, and the offset byte (byte 19) SHALL be included only where the offset range covers it.

Reset
REQ-015 While rst=1 at a clk edge, the block SHALL apply all of the following:
- state=IDLE
- sample_ready=1
- sample_output=24'h000000
- internal datapath registers cleared
REQ-016 rst asserted mid-computation SHALL abort the computation with no DONE cycle and no output update.
REQ-017 rst SHALL take priority over a simultaneous sample_init.

Configuration
REQ-018 When SAMPLER_TRACE_EN is defined, the block SHALL $display the following, each once per computation:
- offset and code in TRUNC
- remainder at MOD->BCD
- the six digits in DONE
REQ-019 When SAMPLER_TRACE_EN is undefined, no simulation output SHALL be produced, and cycle behaviour SHALL be identical in both cases.

Structure
REQ-020 The shared package totp_pkg SHALL hold the following:
- state encoding
- TOTP_MODULUS (1_000_000)
- TOTP_DIGITS (6)
- MOD_STEPS (12)
- BCD_STEPS (20)
- SAMPLER_LATENCY (34)
REQ-021 Double-dabble conversion SHALL be a sub-module bin2bcd_dd with the following behaviour:
- start/busy handshake
- 20-bit input, 24-bit output
- sequenced by totp_sampler

Verification
REQ-022 Digest 1f8698690e02ca16618550ef7f19da8e945b555a, one-cycle sample_init -> offset 0xA, code 0x50EF7F19, sample_output=24'h872921 on the cycle sample_ready rises, 34 edges after capture.
REQ-023 Digests cc93cf18508d94934c64b65d8ba7667fb7cde4b0 then 75a48a19d4cbe100644e8ac1397eea747a2d33ab, each started when ready -> 24'h755224 then 24'h287082.
REQ-024 Offset 15: bytes 15..18=FF, byte 19=0x0F, other bytes 0 -> code 0x7FFFFFFF -> 24'h483647.
REQ-025 Word at offset 0 = 0x000F423F, then 0x000F4240, then all-zero digest -> 24'h999999, then 24'h000000, then 24'h000000.
REQ-026 Busy-input checks SHALL produce the following responses:
- sample_init re-pulsed at cycles 5 and 20 of a computation -> single result at edge 34, ready never glitches high early
- rst pulsed at cycle 10 -> ready=1 and output=0 on the next cycle, and no result appears afterwards
